// File: rtl/audio_mix_pkg.sv
// Shared definitions for the audio mixer / PWM output stage:
// config select codes, CTRL bit positions, reset constants and the mix helper.
`timescale 1ns/1ps

package audio_mix_pkg;

    localparam int MIX_W = 6;

    typedef enum logic [1:0] {
        SEL_VOL0 = 2'd0,
        SEL_VOL1 = 2'd1,
        SEL_CTRL = 2'd2,
        SEL_NONE = 2'd3
    } cfg_sel_e;

    localparam int CTRL_SQ0_EN = 0;
    localparam int CTRL_SQ1_EN = 1;
    localparam int CTRL_TRI_EN = 2;
    localparam int CTRL_MUTE   = 3;

    localparam logic [3:0] VOL_RST  = 4'h8;
    localparam logic [3:0] CTRL_RST = 4'b0111;

    // Weighted sum of the three sources; 15 + 15 + 15 = 45 fits in MIX_W bits.
    function automatic logic [MIX_W-1:0] mix_calc(
        input logic [3:0] tri_w,
        input logic       sq0_w,
        input logic       sq1_w,
        input logic [3:0] vol0,
        input logic [3:0] vol1,
        input logic [3:0] ctrl
    );
        logic [MIX_W-1:0] sum;
        sum = '0;
        if (ctrl[CTRL_TRI_EN])
            sum = sum + MIX_W'(tri_w);
        if (ctrl[CTRL_SQ0_EN] && sq0_w)
            sum = sum + MIX_W'(vol0);
        if (ctrl[CTRL_SQ1_EN] && sq1_w)
            sum = sum + MIX_W'(vol1);
        if (ctrl[CTRL_MUTE])
            sum = '0;
        return sum;
    endfunction

endpackage

// File: rtl/audio_mix_mod.sv
// Period counter, sample latch and output modulator of the audio stage.
// Build option: define SIGMA_DELTA_EN to replace the PWM comparator with a
// first-order sigma-delta modulator (same high count per period, spread edges).
`timescale 1ns/1ps

module audio_mix_mod
    import audio_mix_pkg::*;
#(
    parameter int PWM_BITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MIX_W-1:0] mix,
    output logic             boundary,
    output logic             pwm_out,
    output logic             sample_stb
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] sample_q;
    logic [PWM_BITS-1:0] sample_next;

    // Last cycle of the period; the parent also uses it to load active config.
    assign boundary    = (cnt == '1);
    assign sample_next = PWM_BITS'(mix) << (PWM_BITS - MIX_W);

    // Free-running period counter, sample latch and start-of-period strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sample_q   <= '0;
            sample_stb <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            sample_stb <= boundary;
            if (boundary)
                sample_q <= sample_next;
        end
    end

`ifdef SIGMA_DELTA_EN
    logic [PWM_BITS:0] acc;
    logic [PWM_BITS:0] acc_sum;

    assign acc_sum = {1'b0, acc[PWM_BITS-1:0]} + {1'b0, sample_q};
    // The carry of the registered sum is the output bit, so it is already registered.
    assign pwm_out = acc[PWM_BITS];

    // Accumulate the sample every cycle; carries average to sample_q per period.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else
            acc <= acc_sum;
    end
`else
    // Comparator PWM: high for the first sample_q counts of each period.
    always_ff @(posedge clk) begin
        if (rst)
            pwm_out <= 1'b0;
        else
            pwm_out <= (cnt < sample_q);
    end
`endif

endmodule

// File: rtl/audio_mix_pwm.sv
// Audio output stage: registers the generator outputs, mixes them with
// double-buffered volume/control settings and drives a one-pin audio output.
// Build option: SIGMA_DELTA_EN selects sigma-delta instead of PWM in audio_mix_mod.
`timescale 1ns/1ps

module audio_mix_pwm
    import audio_mix_pkg::*;
#(
    parameter int PWM_BITS = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] TRI,
    input  logic       SQ0,
    input  logic       SQ1,
    input  logic       CFG_WR,
    input  logic [1:0] CFG_SEL,
    input  logic [3:0] CFG_DIN,
    output logic       PWM_OUT,
    output logic       SAMPLE_STB
);

    logic [3:0]       tri_r;
    logic             sq0_r;
    logic             sq1_r;
    logic [3:0]       vol0_sh, vol1_sh, ctrl_sh;
    logic [3:0]       vol0_act, vol1_act, ctrl_act;
    logic [MIX_W-1:0] mix;
    logic             boundary;

    // One-cycle input register on the generator outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tri_r <= '0;
            sq0_r <= 1'b0;
            sq1_r <= 1'b0;
        end else begin
            tri_r <= TRI;
            sq0_r <= SQ0;
            sq1_r <= SQ1;
        end
    end

    // Shadow registers take writes at any time; select 3 is a no-op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vol0_sh <= VOL_RST;
            vol1_sh <= VOL_RST;
            ctrl_sh <= CTRL_RST;
        end else if (CFG_WR) begin
            case (CFG_SEL)
                SEL_VOL0: vol0_sh <= CFG_DIN;
                SEL_VOL1: vol1_sh <= CFG_DIN;
                SEL_CTRL: ctrl_sh <= CFG_DIN;
                default:  ;
            endcase
        end
    end

    // Active settings change only at the period boundary so a period never mixes two configs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vol0_act <= VOL_RST;
            vol1_act <= VOL_RST;
            ctrl_act <= CTRL_RST;
        end else if (boundary) begin
            vol0_act <= vol0_sh;
            vol1_act <= vol1_sh;
            ctrl_act <= ctrl_sh;
        end
    end

    // Mix the registered sources with the active settings.
    always_comb begin
        mix = mix_calc(tri_r, sq0_r, sq1_r, vol0_act, vol1_act, ctrl_act);
    end

    audio_mix_mod #(
        .PWM_BITS (PWM_BITS)
    ) u_mod (
        .clk        (CLK),
        .rst        (RST),
        .mix        (mix),
        .boundary   (boundary),
        .pwm_out    (PWM_OUT),
        .sample_stb (SAMPLE_STB)
    );

endmodule

// File: tb/tb_audio_mix_pwm.sv
// Self-checking bench for audio_mix_pwm (PWM_BITS=6, 64-cycle period).
`timescale 1ns/1ps

module tb_audio_mix_pwm;
    import audio_mix_pkg::*;

    localparam int PERIOD = 64;

    typedef struct {
        logic [3:0] tri_v;
        logic       sq0;
        logic       sq1;
        logic [3:0] vol0;
        logic [3:0] vol1;
        logic [3:0] ctrl;
        int         highs;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] TRI = '0;
    logic       SQ0 = 1'b0;
    logic       SQ1 = 1'b0;
    logic       CFG_WR = 1'b0;
    logic [1:0] CFG_SEL = '0;
    logic [3:0] CFG_DIN = '0;
    logic       PWM_OUT;
    logic       SAMPLE_STB;

    int    checks = 0;
    int    failures = 0;
    int    exp_q[$];
    string name_q[$];
    vec_t  vecs[$];

    audio_mix_pwm #(.PWM_BITS(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TRI        (TRI),
        .SQ0        (SQ0),
        .SQ1        (SQ1),
        .CFG_WR     (CFG_WR),
        .CFG_SEL    (CFG_SEL),
        .CFG_DIN    (CFG_DIN),
        .PWM_OUT    (PWM_OUT),
        .SAMPLE_STB (SAMPLE_STB)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] t, input logic s0, input logic s1,
                                input logic [3:0] v0, input logic [3:0] v1,
                                input logic [3:0] c, input int h);
        vec_t v;
        v.tri_v = t; v.sq0 = s0; v.sq1 = s1;
        v.vol0 = v0; v.vol1 = v1; v.ctrl = c; v.highs = h;
        return v;
    endfunction

    task automatic expect_period(input string nm, input int highs);
        exp_q.push_back(highs);
        name_q.push_back(nm);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] din);
        CFG_SEL = sel;
        CFG_DIN = din;
        CFG_WR  = 1'b1;
        @(posedge CLK);
        #1;
        CFG_WR  = 1'b0;
    endtask

    // Advance to the next SAMPLE_STB cycle (not the current one), sampled at negedge.
    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3 * PERIOD; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (SAMPLE_STB) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Measure the 64 output cycles following the next strobe and compare to the scoreboard.
    task automatic measure(output int toggles);
        bit    ok;
        int    highs;
        int    bad_shape;
        int    exp;
        logic  prev;
        string nm;
        toggles = 0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        wait_stb(ok);
        if (!ok) begin
            check({nm, "_stb_timeout"}, 0, 1);
            return;
        end
        highs = 0;
        bad_shape = 0;
        prev = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge CLK);
            if (PWM_OUT === 1'b1) highs++;
            if (PWM_OUT !== ((i < exp) ? 1'b1 : 1'b0)) bad_shape++;
            if (i > 0 && PWM_OUT !== prev) toggles++;
            prev = PWM_OUT;
        end
        check({nm, "_highs"}, highs, exp);
`ifndef SIGMA_DELTA_EN
        check({nm, "_shape"}, bad_shape, 0);
`endif
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        bit ok;
        int tg;
        cfg_write(SEL_VOL0, v.vol0);
        cfg_write(SEL_VOL1, v.vol1);
        cfg_write(SEL_CTRL, v.ctrl);
        TRI = v.tri_v;
        SQ0 = v.sq0;
        SQ1 = v.sq1;
        expect_period(nm, v.highs);
        wait_stb(ok);
        if (!ok) check({nm, "_settle_timeout"}, 0, 1);
        measure(tg);
    endtask

    task automatic count_to_first_stb(input string nm);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 4 * PERIOD && !seen) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (SAMPLE_STB) seen = 1'b1;
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
        else       check(nm, n, PERIOD);
    endtask

    initial begin
        int tg;

        vecs.push_back(mk(4'd15, 1'b0, 1'b0, 4'd8,  4'd8,  4'b0111, 15));
        vecs.push_back(mk(4'd15, 1'b1, 1'b1, 4'd15, 4'd15, 4'b0111, 45));
        vecs.push_back(mk(4'd0,  1'b1, 1'b0, 4'd5,  4'd8,  4'b0111, 5));
        vecs.push_back(mk(4'd3,  1'b0, 1'b1, 4'd8,  4'd9,  4'b0111, 12));
        vecs.push_back(mk(4'd9,  1'b1, 1'b1, 4'd2,  4'd4,  4'b0011, 6));
        vecs.push_back(mk(4'd7,  1'b1, 1'b1, 4'd8,  4'd8,  4'b0100, 7));
        vecs.push_back(mk(4'd15, 1'b1, 1'b1, 4'd8,  4'd8,  4'b1111, 0));
        vecs.push_back(mk(4'd0,  1'b0, 1'b0, 4'd8,  4'd8,  4'b0111, 0));
        vecs.push_back(mk(4'd1,  1'b0, 1'b0, 4'd8,  4'd8,  4'b0111, 1));
        vecs.push_back(mk(4'd5,  1'b1, 1'b1, 4'd3,  4'd8,  4'b0110, 13));

        // Reset held for two edges, then first strobe 64 edges after release.
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_pwm_out", int'(PWM_OUT), 0);
        check("rst_sample_stb", int'(SAMPLE_STB), 0);
        RST = 1'b0;
        count_to_first_stb("rst_first_stb");

        // Table of steady-state mixes.
        for (int i = 0; i < vecs.size(); i++)
            apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Mid-period VOL0 write: one more period at the old level, then the new one.
        apply_vec(mk(4'd0, 1'b1, 1'b0, 4'd8, 4'd8, 4'b0111, 8), "vol_pre");
        repeat (20) @(negedge CLK);
        cfg_write(SEL_VOL0, 4'd2);
        expect_period("vol_mid_old", 8);
        expect_period("vol_mid_new", 2);
        measure(tg);
        measure(tg);

        // Write landing exactly on the boundary edge is deferred one extra period.
        repeat (63) @(posedge CLK);
        #1;
        CFG_SEL = SEL_VOL0;
        CFG_DIN = 4'd5;
        CFG_WR  = 1'b1;
        @(posedge CLK);
        #1;
        CFG_WR  = 1'b0;
        expect_period("bnd_wr_hold", 2);
        expect_period("bnd_wr_new", 5);
        measure(tg);
        measure(tg);

        // Mute on, then off.
        apply_vec(mk(4'd15, 1'b0, 1'b0, 4'd8, 4'd8, 4'b0111, 15), "mute_base");
        cfg_write(SEL_CTRL, 4'b1111);
        expect_period("mute_pre", 15);
        expect_period("mute_on", 0);
        measure(tg);
        measure(tg);
        cfg_write(SEL_CTRL, 4'b0111);
        expect_period("mute_hold", 0);
        expect_period("mute_off", 15);
        measure(tg);
        measure(tg);

        // Select code 3 must not disturb any register.
        apply_vec(mk(4'd15, 1'b1, 1'b0, 4'd8, 4'd8, 4'b0111, 23), "sel3_base");
        cfg_write(2'd3, 4'd0);
        expect_period("sel3_a", 23);
        expect_period("sel3_b", 23);
        measure(tg);
        measure(tg);

        // Reset in the middle of a high stretch at cnt=10.
        repeat (10) @(posedge CLK);
        #1;
        check("mid_rst_pre_high", int'(PWM_OUT), 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_pwm_out", int'(PWM_OUT), 0);
        check("mid_rst_sample_stb", int'(SAMPLE_STB), 0);
        RST = 1'b0;
        count_to_first_stb("mid_rst_first_stb");
        expect_period("post_rst", 23);
        measure(tg);

`ifdef SIGMA_DELTA_EN
        // mix = 8 + 12 + 12 = 32: carry alternates every cycle.
        apply_vec(mk(4'd8, 1'b1, 1'b1, 4'd12, 4'd12, 4'b0111, 32), "sd_base");
        expect_period("sd_half", 32);
        measure(tg);
        check("sd_toggles", tg, PERIOD - 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
